tablero_buscaminas_ctrl: RTL

//  Clocked, parametrised Minesweeper board engine. It places mines from an LFSR or from a manual load port,

---
 rtl/tablero_buscaminas_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tablero_buscaminas_ctrl.sv
// Minesweeper board engine: mine placement (LFSR or manual), neighbour counting,
// reveal/flag moves with valid/ready, zero-region flood fill, win/lose tracking.
module tablero_buscaminas_ctrl #(
    parameter int          FILAS      = 8,
    parameter int          COLUMNAS   = 8,
    parameter int          NUM_BOMBAS = 10,
    parameter logic [15:0] SEMILLA    = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  modo_aleatorio,
    input  logic                                  bomba_we,
    input  logic [3:0]                            bomba_x,
    input  logic [3:0]                            bomba_y,
    input  logic                                  mov_valid,
    output logic                                  mov_ready,
    input  logic [1:0]                            mov_tipo,
    input  logic [3:0]                            pos_x,
    input  logic [3:0]                            pos_y,
    input  logic [3:0]                            rd_x,
    input  logic [3:0]                            rd_y,
    output logic [3:0]                            rd_celda,
    output logic [$clog2(FILAS*COLUMNAS+1)-1:0]   casillas_libres,
    output logic [$clog2(FILAS*COLUMNAS+1)-1:0]   banderas_rest,
    output logic                                  game_over,
    output logic                                  victoria
);
    localparam int          CELDAS     = FILAS * COLUMNAS;
    localparam int          CW         = $clog2(CELDAS + 1);
    localparam int          IDXW       = $clog2(CELDAS);
    localparam logic [15:0] SEMILLA_EF = (SEMILLA == 16'h0000) ? 16'hACE1 : SEMILLA;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_PLACE  = 3'd2,
        S_COUNT  = 3'd3,
        S_READY  = 3'd4,
        S_EXPAND = 3'd5,
        S_WON    = 3'd6,
        S_LOST   = 3'd7
    } estado_t;

    estado_t           estado_r;
    logic [CELDAS-1:0] mina_r, revelada_r, bandera_r;
    logic [3:0]        cuenta_r [CELDAS];
    logic [3:0]        fil_r, col_r;
    logic [CW-1:0]     colocadas_r, total_r, libres_r, banderas_r;
    logic [15:0]       lfsr_r;
    logic              modo_r, mov_ready_r, game_over_r, victoria_r, hubo_rev_r;

    logic [IDXW-1:0]   idx_s, midx_s, bidx_s, ridx_s, cand_s, nidx_s;
    logic [15:0]       lfsr_sig_s;
    logic [CW-1:0]     total_s;
    logic [3:0]        cnt_s;
    logic              cero_s, fin_fila_s, fin_tablero_s, cand_ok_s, exp_rev_s;
    logic              pos_in_s, bomba_in_s, rd_in_s, start_ok_s;
    int                nr, nc;

    assign idx_s         = IDXW'(int'(fil_r) * COLUMNAS + int'(col_r));
    assign midx_s        = IDXW'(int'(pos_x) * COLUMNAS + int'(pos_y));
    assign bidx_s        = IDXW'(int'(bomba_x) * COLUMNAS + int'(bomba_y));
    assign ridx_s        = IDXW'(int'(rd_x) * COLUMNAS + int'(rd_y));
    assign pos_in_s      = (int'(pos_x) < FILAS) && (int'(pos_y) < COLUMNAS);
    assign bomba_in_s    = (int'(bomba_x) < FILAS) && (int'(bomba_y) < COLUMNAS);
    assign rd_in_s       = (int'(rd_x) < FILAS) && (int'(rd_y) < COLUMNAS);
    assign fin_fila_s    = (int'(col_r) == COLUMNAS - 1);
    assign fin_tablero_s = fin_fila_s && (int'(fil_r) == FILAS - 1);
    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    assign lfsr_sig_s    = {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    assign cand_s        = lfsr_r[IDXW-1:0];
    assign cand_ok_s     = (int'(cand_s) < CELDAS) && !mina_r[cand_s];
    assign total_s       = total_r + {{(CW-1){1'b0}}, mina_r[idx_s]};
    assign exp_rev_s     = !revelada_r[idx_s] && !bandera_r[idx_s] && !mina_r[idx_s] && cero_s;
    assign start_ok_s    = start && ((estado_r == S_IDLE) || (estado_r == S_READY) ||
                                     (estado_r == S_WON) || (estado_r == S_LOST));

    // Scan the 8 clipped neighbours of the scan cell: mine count and revealed-zero presence
    always_comb begin
        cnt_s  = 4'd0;
        cero_s = 1'b0;
        nr     = 0;
        nc     = 0;
        nidx_s = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(fil_r) + dr;
                nc = int'(col_r) + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < FILAS && nc >= 0 && nc < COLUMNAS) begin
                    nidx_s = IDXW'(nr * COLUMNAS + nc);
                    if (mina_r[nidx_s]) begin
                        cnt_s = cnt_s + 4'd1;
                    end else begin
                        cnt_s = cnt_s;
                    end
                    if (revelada_r[nidx_s] && cuenta_r[nidx_s] == 4'd0) begin
                        cero_s = 1'b1;
                    end else begin
                        cero_s = cero_s;
                    end
                end else begin
                    nidx_s = nidx_s;
                end
            end
        end
    end

    // Combinational renderer read port
    always_comb begin
        rd_celda = 4'd9;
        if (!rd_in_s) begin
            rd_celda = 4'd15;
        end else if (estado_r == S_LOST && mina_r[ridx_s]) begin
            rd_celda = 4'd11;
        end else if (revelada_r[ridx_s]) begin
            rd_celda = cuenta_r[ridx_s];
        end else if (bandera_r[ridx_s]) begin
            rd_celda = 4'd10;
        end else begin
            rd_celda = 4'd9;
        end
    end

    // Game FSM, board state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r    <= S_IDLE;
            mina_r      <= '0;
            revelada_r  <= '0;
            bandera_r   <= '0;
            for (int i = 0; i < CELDAS; i++) cuenta_r[i] <= 4'd0;
            fil_r       <= 4'd0;
            col_r       <= 4'd0;
            colocadas_r <= '0;
            total_r     <= '0;
            libres_r    <= '0;
            banderas_r  <= '0;
            lfsr_r      <= SEMILLA_EF;
            modo_r      <= 1'b0;
            mov_ready_r <= 1'b0;
            game_over_r <= 1'b0;
            victoria_r  <= 1'b0;
            hubo_rev_r  <= 1'b0;
        end else if (start_ok_s) begin
            estado_r    <= S_CLEAR;
            modo_r      <= modo_aleatorio;
            mov_ready_r <= 1'b0;
            game_over_r <= 1'b0;
            victoria_r  <= 1'b0;
        end else begin
            case (estado_r)
                S_IDLE: begin
                    if (bomba_we && bomba_in_s) mina_r[bidx_s] <= 1'b1;
                end
                S_CLEAR: begin
                    revelada_r  <= '0;
                    bandera_r   <= '0;
                    for (int i = 0; i < CELDAS; i++) cuenta_r[i] <= 4'd0;
                    fil_r       <= 4'd0;
                    col_r       <= 4'd0;
                    colocadas_r <= '0;
                    total_r     <= '0;
                    libres_r    <= '0;
                    banderas_r  <= '0;
                    if (modo_r) begin
                        mina_r   <= '0;
                        estado_r <= S_PLACE;
                    end else begin
                        estado_r <= S_COUNT;
                    end
                end
                S_PLACE: begin
                    lfsr_r <= lfsr_sig_s;
                    if (cand_ok_s) begin
                        mina_r[cand_s] <= 1'b1;
                        colocadas_r    <= colocadas_r + CW'(1);
                        if (colocadas_r == CW'(NUM_BOMBAS - 1)) estado_r <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    cuenta_r[idx_s] <= cnt_s;
                    total_r         <= total_s;
                    if (fin_tablero_s) begin
                        fil_r      <= 4'd0;
                        col_r      <= 4'd0;
                        libres_r   <= CW'(CELDAS) - total_s;
                        banderas_r <= total_s;
                        if (total_s == '0) begin
                            estado_r   <= S_WON;
                            victoria_r <= 1'b1;
                        end else begin
                            estado_r    <= S_READY;
                            mov_ready_r <= 1'b1;
                        end
                    end else if (fin_fila_s) begin
                        col_r <= 4'd0;
                        fil_r <= fil_r + 4'd1;
                    end else begin
                        col_r <= col_r + 4'd1;
                    end
                end
                S_READY: begin
                    if (!mov_ready_r) begin
                        // recovery cycle after each accepted move; win is detected here
                        if (libres_r == '0) begin
                            estado_r   <= S_WON;
                            victoria_r <= 1'b1;
                        end else begin
                            mov_ready_r <= 1'b1;
                        end
                    end else if (mov_valid) begin
                        mov_ready_r <= 1'b0;
                        if (pos_in_s) begin
                            case (mov_tipo)
                                2'd1: begin
                                    if (!revelada_r[midx_s] && !bandera_r[midx_s]) begin
                                        if (mina_r[midx_s]) begin
                                            estado_r    <= S_LOST;
                                            game_over_r <= 1'b1;
                                        end else begin
                                            revelada_r[midx_s] <= 1'b1;
                                            libres_r           <= libres_r - CW'(1);
                                            if (cuenta_r[midx_s] == 4'd0) begin
                                                estado_r   <= S_EXPAND;
                                                fil_r      <= 4'd0;
                                                col_r      <= 4'd0;
                                                hubo_rev_r <= 1'b0;
                                            end
                                        end
                                    end
                                end
                                2'd2: begin
                                    if (bandera_r[midx_s]) begin
                                        bandera_r[midx_s] <= 1'b0;
                                        banderas_r        <= banderas_r + CW'(1);
                                    end else if (!revelada_r[midx_s] && banderas_r != '0) begin
                                        bandera_r[midx_s] <= 1'b1;
                                        banderas_r        <= banderas_r - CW'(1);
                                    end
                                end
                                default: begin
                                    mov_ready_r <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                S_EXPAND: begin
                    if (exp_rev_s) begin
                        revelada_r[idx_s] <= 1'b1;
                        libres_r          <= libres_r - CW'(1);
                    end
                    if (fin_tablero_s) begin
                        fil_r      <= 4'd0;
                        col_r      <= 4'd0;
                        hubo_rev_r <= 1'b0;
                        // a full pass with no reveal means the region is closed
                        if (!(hubo_rev_r || exp_rev_s)) begin
                            if (libres_r == '0) begin
                                estado_r   <= S_WON;
                                victoria_r <= 1'b1;
                            end else begin
                                estado_r    <= S_READY;
                                mov_ready_r <= 1'b1;
                            end
                        end
                    end else begin
                        if (exp_rev_s) hubo_rev_r <= 1'b1;
                        if (fin_fila_s) begin
                            col_r <= 4'd0;
                            fil_r <= fil_r + 4'd1;
                        end else begin
                            col_r <= col_r + 4'd1;
                        end
                    end
                end
                S_WON, S_LOST: begin
                    mov_ready_r <= 1'b0;
                end
                default: begin
                    estado_r <= S_IDLE;
                end
            endcase
        end
    end

    assign mov_ready       = mov_ready_r;
    assign casillas_libres = libres_r;
    assign banderas_rest   = banderas_r;
    assign game_over       = game_over_r;
    assign victoria        = victoria_r;

endmodule
